// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, start-bit qualification, mid-bit data sampling, stop check.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits and the o_parity_err output.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OVS     = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_rx,
  input  logic            i_baud_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err,
  output logic            o_busy
`ifdef UART_RX_PARITY_EN
  , output logic          o_parity_err
`endif
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT) + 1;

  localparam logic [SW-1:0] S_MID  = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] sreg;
  logic            rx_m, rx_s;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      sreg           <= '0;
      o_dout         <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit        <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      o_rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Start detection runs every clock so a start edge is caught regardless of tick phase.
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: if (i_baud_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
        DATA: if (i_baud_tick) begin
          if (s == S_BIT) begin
            s    <= '0;
            sreg <= {rx_s, sreg[DBIT-1:1]};
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (i_baud_tick) begin
          if (s == S_BIT) begin
            s       <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            s <= s + 1'b1;
          end
        end
`endif
        STOP: if (i_baud_tick) begin
          if (s == S_STOP) begin
            o_dout         <= sreg;
            o_frame_err    <= ~rx_s;
            o_rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
            o_parity_err   <= ^sreg ^ par_bit ^ PARITY_ODD;
`endif
            state          <= IDLE;
          end else begin
            s <= s + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 16 ticks/bit, one tick every 4 clocks (64 clocks per bit).
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] dout;
  logic       done, ferr, busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int checks = 0;
  int failures = 0;
  int done_cyc = 0;
  int busy_cyc = 0;
  int tcnt = 0;
  logic [7:0] cap[$];

  uart_rx #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx(rx), .i_baud_tick(tick),
    .o_dout(dout), .o_rx_done_tick(done), .o_frame_err(ferr), .o_busy(busy)
`ifdef UART_RX_PARITY_EN
    , .o_parity_err(perr)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    tick = (tcnt == 0);
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cyc = done_cyc + 1;
      cap.push_back(dout);
    end
    if (busy === 1'b1) busy_cyc = busy_cyc + 1;
  end

  function automatic logic [7:0] cap_at(input int idx);
    return (idx >= 0 && idx < cap.size()) ? cap[idx] : 8'hxx;
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  // par_flip=0 sends correct even parity when the parity build is enabled.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int stop_len, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ par_flip);
`endif
    rx = stop_b;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ferr !== 1'b0)  begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    int c0, b0, q0;
    c0 = done_cyc; b0 = busy_cyc; q0 = cap.size();
    send_frame(8'hA5, 1'b1, 64, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (done_cyc - c0 !== 1) begin failures++; $display("FAIL basic_done_cycles got=%0d exp=1", done_cyc - c0); end
    checks++; if (cap_at(q0) !== 8'hA5) begin failures++; $display("FAIL basic_dout got=%h exp=a5", cap_at(q0)); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b exp=0", ferr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    checks++;
    if (busy_cyc - b0 < 580 || busy_cyc - b0 > 630) begin
      failures++; $display("FAIL basic_busy_len got=%0d exp=580..630", busy_cyc - b0);
    end
  endtask

  task automatic test_back_to_back;
    int c0, q0;
    c0 = done_cyc; q0 = cap.size();
    send_frame(8'h3C, 1'b1, 64, 1'b0);
    send_frame(8'hC3, 1'b1, 64, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (done_cyc - c0 !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cyc - c0); end
    checks++; if (cap_at(q0) !== 8'h3C) begin failures++; $display("FAIL b2b_first got=%h exp=3c", cap_at(q0)); end
    checks++; if (cap_at(q0+1) !== 8'hC3) begin failures++; $display("FAIL b2b_second got=%h exp=c3", cap_at(q0+1)); end
  endtask

  task automatic test_glitch;
    int c0;
    c0 = done_cyc;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_cyc !== c0) begin failures++; $display("FAIL glitch_done got=%0d exp=%0d", done_cyc, c0); end
    checks++; if (dout !== 8'hC3) begin failures++; $display("FAIL glitch_dout got=%h exp=c3", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_frame_err;
    int c0, q0;
    c0 = done_cyc; q0 = cap.size();
    // Low stop bit is cut short so the trailing low level is rejected as a glitch.
    send_frame(8'h55, 1'b0, 48, 1'b0);
    repeat (128) @(negedge clk);
    checks++; if (done_cyc - c0 !== 1) begin failures++; $display("FAIL ferr_done got=%0d exp=1", done_cyc - c0); end
    checks++; if (cap_at(q0) !== 8'h55) begin failures++; $display("FAIL ferr_dout got=%h exp=55", cap_at(q0)); end
    checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", ferr); end
    send_frame(8'h0F, 1'b1, 64, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (dout !== 8'h0F) begin failures++; $display("FAIL ferr_next_dout got=%h exp=0f", dout); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL ferr_cleared got=%b exp=0", ferr); end
  endtask

  task automatic test_reset_mid;
    int c0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    c0 = done_cyc;
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rmid_dout got=%h exp=00", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL rmid_ferr got=%b exp=0", ferr); end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_cyc !== c0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_cyc, c0); end
    send_frame(8'h81, 1'b1, 64, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (done_cyc - c0 !== 1) begin failures++; $display("FAIL rmid_next_done got=%0d exp=1", done_cyc - c0); end
    checks++; if (dout !== 8'h81) begin failures++; $display("FAIL rmid_next_dout got=%h exp=81", dout); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    // 0x07 has three ones: parity bit 1 is correct even parity, 0 is wrong.
    send_frame(8'h07, 1'b1, 64, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (dout !== 8'h07) begin failures++; $display("FAIL par_good_dout got=%h exp=07", dout); end
    checks++; if (perr !== 1'b0) begin failures++; $display("FAIL par_good_flag got=%b exp=0", perr); end
    send_frame(8'h07, 1'b1, 64, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (perr !== 1'b1) begin failures++; $display("FAIL par_bad_flag got=%b exp=1", perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
